// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fixup cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [WIDTH-1:0]       araw_q, araw_d;
    logic                   is_div_q, is_div_d;
    logic                   sa_q, sa_d;
    logic                   sb_q, sb_d;
    logic                   dz_q, dz_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   op_signed_s;
    logic [WIDTH:0]         mul_sum_s;
    logic [WIDTH:0]         div_trial_s;
    logic [WIDTH-1:0]       quo_s;
    logic [WIDTH-1:0]       rem_s;
    logic [2*WIDTH-1:0]     prod_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic en);
        if (en && x[WIDTH-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    // Next-state, datapath step and HI/LO update logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        araw_d      = araw_q;
        is_div_d    = is_div_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        dz_d        = dz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        op_signed_s = ~op[0];
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        quo_s       = acc_q[WIDTH-1:0];
        rem_s       = acc_q[2*WIDTH-1:WIDTH];
        prod_s      = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    sa_d     = op_signed_s & a[WIDTH-1];
                    sb_d     = op_signed_s & b[WIDTH-1];
                    dz_d     = op[1] & (b == '0);
                    araw_d   = a;
                    // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_val(a, op_signed_s)};
                        opnd_d = abs_val(b, op_signed_s);
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_val(b, op_signed_s)};
                        opnd_d = abs_val(a, op_signed_s);
                    end
                end else begin
                    if (mthi) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtlo) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    if (!div_trial_s[WIDTH]) begin
                        acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (acc_q[0]) begin
                        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_SIGN;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_SIGN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (dz_q) begin
                        quo_s = {WIDTH{1'b1}};
                        rem_s = araw_q;
                    end else begin
                        // Remainder follows the dividend sign; -2^(W-1)/-1 wraps naturally.
                        quo_s = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        rem_s = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
                    hi_d   = prod_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_s[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            araw_q   <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            araw_q   <= araw_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0] ux, uy;
        sx = 64'($signed(x));
        sy = 64'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: return sx * sy;
            2'b01: return ux * uy;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    return {sr[31:0], sq[31:0]};
                end
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb, input bit with_mtlo);
        logic [63:0] exp;
        logic [31:0] lo_before;
        int cyc;
        bit busy_ok;
        bit got_done;
        exp = ref_result(o, x, y);
        @(negedge clk);
        lo_before = lo;
        start = 1'b1; op = o; a = x; b = y;
        mtlo  = with_mtlo; wdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        if (with_mtlo) check_eq({tag, "_start_mtlo_lo"}, {32'd0, lo}, {32'd0, lo_before});
        cyc = 0; busy_ok = 1'b1; got_done = 1'b0;
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            start = disturb && (cyc == 4);
            mthi  = disturb && (cyc == 5);
            wdata = 32'h0000_DEAD;
            @(posedge clk); #1;
            cyc++;
            if (done) got_done = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0; mthi = 1'b0;
        check_eq({tag, "_latency"}, 64'(cyc), 64'd33);
        check_eq({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
        check_eq({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        bit seen_done;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op("multu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op("mult_disturb", 2'b00, 32'h0001_2345, 32'hFFFF_0F0F, 1'b1, 1'b0);

        @(negedge clk);
        mthi = 1'b1; wdata = 32'h0000_DEAD;
        @(posedge clk); #1;
        mthi = 1'b0;
        check_eq("idle_mthi", {32'd0, hi}, 64'h0000_DEAD);

        run_op("start_mtlo", 2'b01, 32'd6, 32'd7, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (i % 8 == 0) ry = 32'd0;
            else if (i % 3 == 0) ry = 32'($urandom_range(1, 15));
            if (i % 5 == 0) rx = 32'h8000_0000;
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, 1'b0, 1'b0);
        end

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check_eq("idle_both_hi", {32'd0, hi}, 64'h5A5A_5A5A);
        check_eq("idle_both_lo", {32'd0, lo}, 64'h5A5A_5A5A);

        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        check_eq("abort_hi", {32'd0, hi}, 64'd0);
        check_eq("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check_eq("abort_no_done", {63'd0, seen_done}, 64'd0);
        check_eq("abort_idle_busy", {63'd0, busy}, 64'd0);

        run_op("post_rst_multu", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
